// File: rtl/codificador_prioridad_seq_pkg.sv
// rtl/codificador_prioridad_seq_pkg.sv - shared types and helpers for the priority encoder family
//
// Purpose: state encoding and small width/bit-count helpers shared by the
// sequential priority encoder, its interface and the combinational encoder.
// Ports: none (package).

package codificadores_pkg;

   typedef enum logic {
      REPOSO = 1'b0,
      EMITIR = 1'b1
   } estado_t;

   // Index width for an n-entry vector; never below 1 so N=2 still gets a bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

   // Exactly one bit set. Callers zero-extend their vector to 64 bits.
   function automatic logic onehot(input logic [63:0] v);
      return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
   endfunction

endpackage

// File: rtl/codificador_prioridad_seq_if.sv
// rtl/codificador_prioridad_seq_if.sv - request load / index handshake bundle
//
// Purpose: groups the load side (en, carga, e, abortar), the index stream
// (s, valido, acepta, fin) and the status flags (listo, ninguno).
// Modports: master = request producer / index consumer, slave = encoder.

interface codificador_prioridad_seq_if
   import codificadores_pkg::*;
#(
   parameter int N = 8
);
   localparam int W = clog2(N);

   logic         en;
   logic         carga;
   logic [N-1:0] e;
   logic         abortar;
   logic         listo;
   logic [W-1:0] s;
   logic         valido;
   logic         acepta;
   logic         fin;
   logic         ninguno;

   modport master (
      output en, carga, e, abortar, acepta,
      input  listo, s, valido, fin, ninguno
   );

   modport slave (
      input  en, carga, e, abortar, acepta,
      output listo, s, valido, fin, ninguno
   );
endinterface

// File: rtl/codificador_prioridad.sv
// rtl/codificador_prioridad.sv - combinational N-to-W priority encoder
//
// Purpose: index of the highest (MSB_FIRST=1) or lowest (MSB_FIRST=0) set
// bit of d; idx is 0 when no bit is set.
// Ports: d (N-bit input vector), idx (W-bit index), alguno (any bit set).

module codificador_prioridad
   import codificadores_pkg::*;
#(
   parameter int N         = 8,
   parameter bit MSB_FIRST = 1'b1,
   localparam int W        = clog2(N)
) (
   input  logic [N-1:0] d,
   output logic [W-1:0] idx,
   output logic         alguno
);

   // The loop direction is chosen so the winning bit is the last one written.
   always_comb begin
      idx    = '0;
      alguno = |d;
      if (MSB_FIRST) begin
         for (int i = 0; i < N; i++)
            if (d[i]) idx = W'(i);
      end else begin
         for (int i = N - 1; i >= 0; i--)
            if (d[i]) idx = W'(i);
      end
   end

endmodule

// File: rtl/codificador_prioridad_seq.sv
// rtl/codificador_prioridad_seq.sv - sequential priority encoder, one index per handshake
//
// Purpose: captures a request vector and emits the index of every set bit in
// priority order, one per valido/acepta transfer.
// Ports: clk, rst_n (async active-low), bus (slave modport): en, carga, e,
// abortar, acepta in; listo, s, valido, fin, ninguno out.

module codificador_prioridad_seq
   import codificadores_pkg::*;
#(
   parameter int N         = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   codificador_prioridad_seq_if.slave bus
);

   localparam int W = clog2(N);

   estado_t      estado, estado_sig;
   logic [N-1:0] pendiente, pendiente_sig;
   logic         ninguno_q, ninguno_sig;
   logic [W-1:0] indice;
   logic         alguno;
   logic         ultimo;

   codificador_prioridad #(
      .N         (N),
      .MSB_FIRST (MSB_FIRST)
   ) u_codificador (
      .d      (pendiente),
      .idx    (indice),
      .alguno (alguno)
   );

   assign ultimo = (estado == EMITIR) && onehot(64'(pendiente));

   // Outputs come from registers only; no input reaches them combinationally.
   assign bus.listo   = (estado == REPOSO);
   assign bus.valido  = (estado == EMITIR);
   assign bus.s       = alguno ? indice : '0;
   assign bus.fin     = ultimo;
   assign bus.ninguno = ninguno_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado    <= REPOSO;
         pendiente <= '0;
         ninguno_q <= 1'b0;
      end else begin
         estado    <= estado_sig;
         pendiente <= pendiente_sig;
         ninguno_q <= ninguno_sig;
      end
   end

   always_comb begin
      estado_sig    = estado;
      pendiente_sig = pendiente;
      ninguno_sig   = 1'b0;
      if (bus.abortar) begin
         // Flush wins over both a load and an in-flight transfer.
         estado_sig    = REPOSO;
         pendiente_sig = '0;
      end else begin
         case (estado)
            REPOSO: begin
               if (bus.en && bus.carga) begin
                  if (|bus.e) begin
                     pendiente_sig = bus.e;
                     estado_sig    = EMITIR;
                  end else begin
                     ninguno_sig = 1'b1;
                  end
               end
            end
            EMITIR: begin
               if (bus.acepta) begin
                  pendiente_sig = pendiente & ~(N'(1) << indice);
                  if (ultimo) estado_sig = REPOSO;
               end
            end
            default: estado_sig = REPOSO;
         endcase
      end
   end

endmodule

// File: tb/tb_codificador_prioridad_seq.sv
// tb/tb_codificador_prioridad_seq.sv - bench for codificador_prioridad_seq (N=8 both orders, N=5)

module tb_codificador_prioridad_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       carga = 1'b0;
   logic [7:0] e = 8'h00;
   logic       abortar = 1'b0;
   logic       acepta = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   codificador_prioridad_seq_if #(.N(8)) i8m ();
   codificador_prioridad_seq_if #(.N(8)) i8l ();
   codificador_prioridad_seq_if #(.N(5)) i5  ();

   assign i8m.en = en;  assign i8m.carga = carga;  assign i8m.e = e;
   assign i8m.abortar = abortar;  assign i8m.acepta = acepta;
   assign i8l.en = en;  assign i8l.carga = carga;  assign i8l.e = e;
   assign i8l.abortar = abortar;  assign i8l.acepta = acepta;
   assign i5.en = en;   assign i5.carga = carga;   assign i5.e = e[4:0];
   assign i5.abortar = abortar;   assign i5.acepta = acepta;

   codificador_prioridad_seq #(.N(8), .MSB_FIRST(1'b1)) u8m (.clk(clk), .rst_n(rst_n), .bus(i8m.slave));
   codificador_prioridad_seq #(.N(8), .MSB_FIRST(1'b0)) u8l (.clk(clk), .rst_n(rst_n), .bus(i8l.slave));
   codificador_prioridad_seq #(.N(5), .MSB_FIRST(1'b1)) u5  (.clk(clk), .rst_n(rst_n), .bus(i5.slave));

   // Model: the set of pending requests per instance as a plain bit vector.
   bit [7:0] mp [3];
   bit       mn [3];
   int       nn [3] = '{8, 8, 5};
   bit       mf [3] = '{1'b1, 1'b0, 1'b1};

   function automatic int next_idx(input bit [7:0] v, input bit msb);
      int r;
      r = 0;
      if (msb) begin
         for (int i = 7; i >= 0; i--) if (v[i]) begin r = i; break; end
      end else begin
         for (int i = 0; i < 8; i++) if (v[i]) begin r = i; break; end
      end
      return r;
   endfunction

   function automatic int popc(input bit [7:0] v);
      int c;
      c = 0;
      for (int i = 0; i < 8; i++) c += int'(v[i]);
      return c;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 3; k++) begin
            mp[k] <= 8'h00;
            mn[k] <= 1'b0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            automatic bit [7:0] em = (nn[k] == 8) ? e : (e & 8'h1F);
            automatic bit [7:0] nx = mp[k];
            automatic bit       nz = 1'b0;
            if (abortar) nx = 8'h00;
            else if (mp[k] == 8'h00) begin
               if (en && carga) begin
                  if (em != 8'h00) nx = em;
                  else nz = 1'b1;
               end
            end else if (acepta) nx[next_idx(mp[k], mf[k])] = 1'b0;
            mp[k] <= nx;
            mn[k] <= nz;
         end
      end
   end

   task automatic cmp(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_inst(input int k, input string tag, input bit listo, input bit valido,
                           input int s, input bit fin, input bit nin);
      automatic bit busy = (mp[k] != 8'h00);
      cmp({tag, ".listo"},   int'(listo),  int'(!busy));
      cmp({tag, ".valido"},  int'(valido), int'(busy));
      cmp({tag, ".s"},       s,            busy ? next_idx(mp[k], mf[k]) : 0);
      cmp({tag, ".fin"},     int'(fin),    int'(busy && popc(mp[k]) == 1));
      cmp({tag, ".ninguno"}, int'(nin),    int'(mn[k]));
   endtask

   always @(negedge clk) begin
      chk_inst(0, "n8msb", i8m.listo, i8m.valido, int'(i8m.s), i8m.fin, i8m.ninguno);
      chk_inst(1, "n8lsb", i8l.listo, i8l.valido, int'(i8l.s), i8l.fin, i8l.ninguno);
      chk_inst(2, "n5msb", i5.listo,  i5.valido,  int'(i5.s),  i5.fin,  i5.ninguno);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) step();
      cmp("reset_listo", int'(i8m.listo), 1);
      cmp("reset_valido", int'(i8m.valido), 0);
      rst_n = 1'b1;
      step();

      // 1: MSB-first burst 7,5,1 with acepta held high
      en = 1'b1; carga = 1'b1; e = 8'b1010_0010; acepta = 1'b1;
      step(); carga = 1'b0;
      cmp("t1_s0", int'(i8m.s), 7);
      step(); cmp("t1_s1", int'(i8m.s), 5);
      step(); cmp("t1_s2", int'(i8m.s), 1); cmp("t1_fin", int'(i8m.fin), 1);
      step(); cmp("t1_listo", int'(i8m.listo), 1);

      // 2: LSB-first with stalls
      acepta = 1'b0; carga = 1'b1; e = 8'b1010_0010;
      step(); carga = 1'b0;
      cmp("t2_s0", int'(i8l.s), 1);
      step(); cmp("t2_hold", int'(i8l.s), 1); cmp("t2_hold_v", int'(i8l.valido), 1);
      acepta = 1'b1; step(); cmp("t2_s1", int'(i8l.s), 5);
      acepta = 1'b0; step(); cmp("t2_s1h", int'(i8l.s), 5);
      acepta = 1'b1; step(); cmp("t2_s2", int'(i8l.s), 7); cmp("t2_fin", int'(i8l.fin), 1);
      acepta = 1'b0; step(); cmp("t2_s2h", int'(i8l.s), 7);
      acepta = 1'b1; step(); cmp("t2_listo", int'(i8l.listo), 1);

      // 3: empty loads, with and without en
      acepta = 1'b0; carga = 1'b1; e = 8'h00;
      step(); carga = 1'b0;
      cmp("t3_ninguno", int'(i8m.ninguno), 1); cmp("t3_listo", int'(i8m.listo), 1);
      step(); cmp("t3_ninguno_off", int'(i8m.ninguno), 0);
      en = 1'b0; carga = 1'b1;
      step(); cmp("t3_en0_ninguno", int'(i8m.ninguno), 0);
      e = 8'b1010_0010;
      step(); cmp("t3_en0_listo", int'(i8m.listo), 1); cmp("t3_en0_valido", int'(i8m.valido), 0);
      carga = 1'b0; en = 1'b1;

      // 4: abort during a full-vector burst, then a single-bit load
      e = 8'hFF; carga = 1'b1; acepta = 1'b1;
      step(); carga = 1'b0;
      step(); step(); step();
      cmp("t4_s_before_abort", int'(i8m.s), 4);
      abortar = 1'b1;
      step(); abortar = 1'b0;
      cmp("t4_listo", int'(i8m.listo), 1); cmp("t4_valido", int'(i8m.valido), 0);
      e = 8'h01; carga = 1'b1; acepta = 1'b0;
      step(); carga = 1'b0;
      cmp("t4_s", int'(i8m.s), 0); cmp("t4_fin", int'(i8m.fin), 1);
      acepta = 1'b1;
      step(); cmp("t4_done", int'(i8m.listo), 1);

      // 5: carga ignored while emitting, then async reset mid-emission
      acepta = 1'b0; e = 8'hFF; carga = 1'b1;
      step(); e = 8'h0F;
      step(); carga = 1'b0;
      cmp("t5_s_kept", int'(i8m.s), 7); cmp("t5_fin_kept", int'(i8m.fin), 0);
      #2 rst_n = 1'b0;
      #1;
      cmp("t5_rst_valido", int'(i8m.valido), 0);
      cmp("t5_rst_listo", int'(i8m.listo), 1);
      cmp("t5_rst_s", int'(i8l.s), 0);
      cmp("t5_rst_fin", int'(i5.fin), 0);
      step(); rst_n = 1'b1;
      step();

      // 6: N=5 ordering 4 then 0
      e = 8'h11; carga = 1'b1; acepta = 1'b1;
      step(); carga = 1'b0;
      cmp("t6_s0", int'(i5.s), 4); cmp("t6_fin0", int'(i5.fin), 0);
      step(); cmp("t6_s1", int'(i5.s), 0); cmp("t6_fin1", int'(i5.fin), 1);
      step(); cmp("t6_listo", int'(i5.listo), 1);
      repeat (3) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/codificador_prioridad_seq.md
Name: codificador_prioridad_seq

Overview:
Parametrised sequential successor of the 8-to-3 encoder.
- Captures an N-bit request vector on a load strobe.
- Emits the binary index of every set bit, one per handshake, in priority order (MSB-first or LSB-first).
- Flags the last index and empty loads.
- Sits between interrupt/request collectors and any consumer that must service each request individually.

Parameters:
- N, 8: width of input vector e; N >= 2.
- MSB_FIRST, 1: 1 = highest set index emitted first; 0 = lowest set index first.
- W (localparam, not overridable): $clog2(N), width of index output s.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: global enable; gates acceptance of carga only.
- carga, input, 1: load strobe; captures e when accepted.
- e, input, N: request vector.
- abortar, input, 1: synchronous flush of pending bits.
- listo, output, 1: block idle, carga will be accepted.
- s, output, W: index of current pending bit.
- valido, output, 1: s holds a valid index.
- acepta, input, 1: consumer ready; transfer when valido && acepta.
- fin, output, 1: current s is the last pending index (valid only when valido=1).
- ninguno, output, 1: one-cycle pulse, load captured all-zero vector.

Behaviour:
- Reset (rst_n=0, async): state REPOSO, pendiente=0, valido=0, s=0, fin=0, ninguno=0, listo=1.
- Registers: pendiente[N-1:0], state {REPOSO, EMITIR}, ninguno flop.
- Outputs:
  - listo = (state==REPOSO).
  - valido = (state==EMITIR).
  - s = priority encode of pendiente per MSB_FIRST, forced to 0 when pendiente==0.
  - fin = valido && exactly one bit of pendiente set.
  - All outputs are driven from registers through combinational logic only; none depend combinationally on any input.
- REPOSO:
  - If en && carga && e!=0: pendiente<=e, go EMITIR. valido rises the cycle after the load edge (latency 1).
  - If en && carga && e==0: ninguno pulses high for exactly one cycle after the edge; stay REPOSO.
  - carga with en=0: ignored.
- EMITIR:
  - On valido && acepta, clear the bit at index s in pendiente.
  - If that was the last bit (fin=1), go REPOSO next cycle. valido is low on that cycle; listo is high.
  - Otherwise stay EMITIR; s advances to the next index on the following cycle. Back-to-back transfers run at 1 index/cycle when acepta is held high.
  - valido, once high, holds with stable s until accepted or aborted. en=0 does not stall or drop it.
  - carga is ignored (listo=0); no queuing.
- abortar:
  - Highest synchronous priority: pendiente<=0, state<=REPOSO, ninguno<=0.
  - A simultaneous acepta transfer is discarded.
  - A simultaneous carga in REPOSO is also dropped.
- Order: MSB_FIRST=1 emits N-1 down to 0; MSB_FIRST=0 emits 0 up to N-1. Bit N-1 alone yields s=N-1.
- Non-power-of-two N: s never exceeds N-1.
- Async reset mid-emission: all pending bits are lost immediately; no output glitch is required to be suppressed.

Decomposition:
- Shared package (codificadores_pkg):
  - state enum {REPOSO, EMITIR}.
  - clog2 helper function.
  - Single-bit-check helper (onehot, used for fin).
- Sub-module codificador_prioridad:
  - Purely combinational N-to-W priority encoder with parameters N and MSB_FIRST.
  - Outputs: index and any-bit flag.
  - Instantiated once on pendiente.
  - Reused standalone elsewhere as the generalised replacement for fixed 8-to-3 encoders.

Test Plan:
1. N=8, MSB_FIRST=1, load e=8'b1010_0010, acepta=1 constantly -> s sequence 7,5,1 on three consecutive cycles starting 1 cycle after load; fin=1 only with s=1; listo=1 on the 4th cycle.
2. Same vector, MSB_FIRST=0, acepta toggling 1,0,1,0,1 -> s=1 held through the stall, then 5, then 7; valido never drops while bits are pending.
3. Load e=0 with en=1 -> ninguno high exactly one cycle, valido stays 0, listo stays 1. Repeat with en=0 -> no ninguno pulse, no state change.
4. Load e=8'hFF, accept 3 indices, assert abortar together with acepta -> next cycle valido=0, listo=1, pendiente=0; a new load of 8'h01 then emits s=0 with fin=1.
5. Assert rst_n=0 mid-emission, asynchronously to clk -> valido, s, fin, ninguno go 0 and listo goes 1 before the next edge. carga during EMITIR is ignored (pendiente unchanged).
6. N=5, MSB_FIRST=1, load 5'b10001 -> s=4 then s=0 (W=3); fin correct; s never shows 5-7.
